// File: rtl/udp_tx_fifo_rd_ctrl.sv
// UDP transmit FIFO read controller.
// Drains fixed-size packets from a show-ahead FIFO as an MSB-first byte stream.
module udp_tx_fifo_rd_ctrl #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int PKT_WORDS  = 256,
    parameter int GAP_CYCLES = 12
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_empty,
    input  logic [ADDR_WIDTH:0]   fifo_rd_water_level,
    output logic                  tx_start_en,
    output logic [15:0]           tx_byte_num,
    output logic [7:0]            m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int IW    = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int WW    = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;
    localparam int GW    = $clog2(GAP_CYCLES + 1);
    localparam int TOTAL = PKT_WORDS * BYTES;

    localparam logic [IW-1:0]       LAST_IDX  = IW'(BYTES - 1);
    localparam logic [WW-1:0]       LAST_WORD = WW'(PKT_WORDS - 1);
    localparam logic [GW-1:0]       GAP_END   = GW'(GAP_CYCLES - 1);
    localparam logic [ADDR_WIDTH:0] PKT_LVL   = (ADDR_WIDTH + 1)'(PKT_WORDS);

    typedef enum logic [1:0] {
        IDLE,
        START,
        SEND,
        GAP
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] word_reg;
    logic [IW-1:0]         idx;
    logic [WW-1:0]         wcnt;
    logic [GW-1:0]         gcnt;
    logic                  have;
    logic                  start_q;

    logic hs;
    logic byte_end;
    logic word_end;
    logic reload_due;

    assign hs         = have & m_ready;
    assign byte_end   = (idx == LAST_IDX);
    assign word_end   = (wcnt == LAST_WORD);
    assign reload_due = hs & byte_end & ~word_end;

    assign tx_byte_num = 16'(TOTAL);
    assign tx_start_en = start_q;
    assign m_valid     = have;
    assign m_last      = have & byte_end & word_end;

    // Pop the FIFO on packet start and on each word reload, never when empty.
    always_comb begin
        fifo_rd_en = 1'b0;
        unique case (state)
            START:   fifo_rd_en = ~fifo_empty;
            SEND:    fifo_rd_en = (reload_due | ~have) & ~fifo_empty;
            default: fifo_rd_en = 1'b0;
        endcase
    end

    // Select the current byte of the held word, most significant first.
    always_comb begin
        m_data = '0;
        for (int i = 0; i < BYTES; i++) begin
            if (idx == IW'(i)) begin
                m_data = word_reg[DATA_WIDTH-1-8*i -: 8];
            end
        end
    end

    // Packet sequencing: wait for a full packet, stream it, then idle a gap.
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            state    <= IDLE;
            word_reg <= '0;
            idx      <= '0;
            wcnt     <= '0;
            gcnt     <= '0;
            have     <= 1'b0;
            start_q  <= 1'b0;
        end else begin
            start_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (fifo_rd_water_level >= PKT_LVL && !fifo_empty) begin
                        state   <= START;
                        start_q <= 1'b1;
                    end
                end
                START: begin
                    if (!fifo_empty) begin
                        word_reg <= fifo_rd_data;
                        idx      <= '0;
                        wcnt     <= '0;
                        have     <= 1'b1;
                        state    <= SEND;
                    end
                end
                SEND: begin
                    if (have) begin
                        if (hs) begin
                            if (!byte_end) begin
                                idx <= idx + IW'(1);
                            end else if (word_end) begin
                                have  <= 1'b0;
                                gcnt  <= '0;
                                state <= GAP;
                            end else if (!fifo_empty) begin
                                word_reg <= fifo_rd_data;
                                idx      <= '0;
                                wcnt     <= wcnt + WW'(1);
                            end else begin
                                have <= 1'b0;
                                idx  <= '0;
                            end
                        end
                    end else if (!fifo_empty) begin
                        word_reg <= fifo_rd_data;
                        idx      <= '0;
                        wcnt     <= wcnt + WW'(1);
                        have     <= 1'b1;
                    end
                end
                GAP: begin
                    if (gcnt == GAP_END) begin
                        state <= IDLE;
                    end else begin
                        gcnt <= gcnt + GW'(1);
                    end
                end
            endcase
        end
    end

endmodule
